// File: rtl/conv_alu_pipe.sv
// conv_alu_pipe: three-stage colour convolution pipeline.
//   S1: per-tap, per-channel signed products (pixel unsigned, kernel signed)
//   S2: per-channel sums
//   S3: magnitude (abs or clamp-to-zero), right shift by div, saturation to CW bits
// A single advance enable (!out_valid || out_ready) moves every stage at once,
// so a stalled output freezes the whole pipe and nothing is dropped or duplicated.
// Optional feature: define CONV_ALU_ROUND_EN to round half-up before the shift;
// without it the shift truncates.
module conv_alu_pipe #(
    parameter int NTAPS = 9,
    parameter int NCH   = 3,
    parameter int CW    = 4,
    parameter int KW    = 5,
    parameter int DIVW  = 4,
    parameter int AW    = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NTAPS*NCH*CW-1:0]  din,
    input  logic [NTAPS*KW-1:0]      kernel,
    input  logic [DIVW-1:0]          div,
    input  logic                     mode,
    input  logic [AW-1:0]            raddr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NCH*CW-1:0]        dout,
    output logic [AW-1:0]            waddr
);

    localparam int PW  = CW + KW;                 // product width
    localparam int SW  = PW + $clog2(NTAPS);      // channel sum width
    localparam int MW  = SW + 2;                  // magnitude width, headroom for the rounding add
    localparam int SHW = $clog2(SW);              // clamped shift amount width

    logic                   w_adv;

    // Stage 1 state
    logic                   r_v1;
    logic signed [PW-1:0]   r_prod [NTAPS*NCH];
    logic [DIVW-1:0]        r_div1;
    logic                   r_mode1;
    logic [AW-1:0]          r_addr1;

    // Stage 2 state
    logic                   r_v2;
    logic signed [SW-1:0]   r_sum [NCH];
    logic [DIVW-1:0]        r_div2;
    logic                   r_mode2;
    logic [AW-1:0]          r_addr2;

    // Stage 3 state
    logic                   r_v3;
    logic [NCH*CW-1:0]      r_dout;
    logic [AW-1:0]          r_waddr;

    logic signed [PW-1:0]   w_prod [NTAPS*NCH];
    logic signed [SW-1:0]   w_sum  [NCH];
    logic [NCH*CW-1:0]      w_dout;
    logic [SHW-1:0]         w_sh;

    assign w_adv     = !r_v3 || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_v3;
    assign dout      = r_dout;
    assign waddr     = r_waddr;

    // Products: pixel zero-extended, coefficient sign-extended, both to PW bits.
    // The exact product always fits in PW bits, so the truncating multiply is exact.
    for (genvar gi = 0; gi < NTAPS*NCH; gi++) begin : g_prod
        localparam int T = gi / NCH;
        logic signed [PW-1:0] w_dx;
        logic signed [PW-1:0] w_kx;
        assign w_dx = {{(PW-CW){1'b0}}, din[gi*CW +: CW]};
        assign w_kx = {{(PW-KW){kernel[T*KW+KW-1]}}, kernel[T*KW +: KW]};
        assign w_prod[gi] = w_dx * w_kx;
    end

    // Per-channel accumulation of the registered products.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_sum
        logic signed [SW-1:0] w_acc;
        // Sum the sign-extended products of this channel over all taps.
        always_comb begin
            w_acc = '0;
            for (int t = 0; t < NTAPS; t++) begin
                w_acc = w_acc + {{(SW-PW){r_prod[t*NCH+gi][PW-1]}}, r_prod[t*NCH+gi]};
            end
        end
        assign w_sum[gi] = w_acc;
    end

    // Shift amounts beyond SW-1 behave as SW-1.
    always_comb begin
        if (int'(r_div2) > SW - 1) begin
            w_sh = SHW'(SW - 1);
        end else begin
            w_sh = SHW'(r_div2);
        end
    end

    // Magnitude, optional rounding, shift and saturation per channel.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_out
        logic signed [SW:0]  w_ext;
        logic signed [SW:0]  w_neg;
        logic [MW-1:0]       w_mag;
        logic [MW-1:0]       w_rnd;
        logic [MW-1:0]       w_shf;
        // One extra bit so negating the most negative sum cannot wrap.
        assign w_ext = {r_sum[gi][SW-1], r_sum[gi]};
        assign w_neg = -w_ext;
        // Select magnitude by mode, then round/shift/saturate.
        always_comb begin
            if (w_ext < 0) begin
                w_mag = r_mode2 ? '0 : {1'b0, w_neg};
            end else begin
                w_mag = {1'b0, w_ext};
            end
`ifdef CONV_ALU_ROUND_EN
            if (w_sh == '0) begin
                w_rnd = w_mag;
            end else begin
                w_rnd = w_mag + (MW'(1) << (w_sh - SHW'(1)));
            end
`else
            w_rnd = w_mag;
`endif
            w_shf = w_rnd >> w_sh;
        end
        assign w_dout[gi*CW +: CW] = (w_shf > MW'((1 << CW) - 1)) ? {CW{1'b1}} : w_shf[CW-1:0];
    end

    // Valid chain and output registers: cleared by reset, frozen while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_dout  <= '0;
            r_waddr <= '0;
        end else if (w_adv) begin
            r_v1    <= in_valid;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_dout  <= w_dout;
            r_waddr <= r_addr2;
        end
    end

    // Datapath registers; their contents only matter behind a set valid bit.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int i = 0; i < NTAPS*NCH; i++) begin
                r_prod[i] <= w_prod[i];
            end
            r_div1  <= div;
            r_mode1 <= mode;
            r_addr1 <= raddr;
            for (int c = 0; c < NCH; c++) begin
                r_sum[c] <= w_sum[c];
            end
            r_div2  <= r_div1;
            r_mode2 <= r_mode1;
            r_addr2 <= r_addr1;
        end
    end

endmodule

// File: tb/tb_conv_alu_pipe.sv
// Self-checking bench for conv_alu_pipe: directed vector table, backpressure and
// mid-stream reset sequences, and a randomized stream checked by a scoreboard
// fed from an arithmetic reference model.
module tb_conv_alu_pipe;

    localparam int NTAPS = 9;
    localparam int NCH   = 3;
    localparam int CW    = 4;
    localparam int KW    = 5;
    localparam int DIVW  = 4;
    localparam int AW    = 12;
    localparam int SW    = CW + KW + $clog2(NTAPS);
    localparam int DINW  = NTAPS*NCH*CW;
    localparam int KTW   = NTAPS*KW;
    localparam int OW    = NCH*CW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DINW-1:0]   din;
    logic [KTW-1:0]    kernel;
    logic [DIVW-1:0]   div;
    logic              mode;
    logic [AW-1:0]     raddr;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     dout;
    logic [AW-1:0]     waddr;

    conv_alu_pipe #(
        .NTAPS(NTAPS), .NCH(NCH), .CW(CW), .KW(KW), .DIVW(DIVW), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .kernel(kernel), .div(div), .mode(mode), .raddr(raddr),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .waddr(waddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DINW-1:0] din;
        logic [KTW-1:0]  kernel;
        logic [DIVW-1:0] div;
        logic            mode;
        logic [OW-1:0]   exp;
    } vec_t;

    typedef struct {
        logic [OW-1:0] dout;
        logic [AW-1:0] waddr;
    } sb_t;

    int     n_cmp = 0;
    int     n_err = 0;
    int     n_out = 0;
    logic   saw_stall = 1'b0;
    logic   prev_hold = 1'b0;
    logic [OW-1:0] prev_dout;
    logic [AW-1:0] prev_waddr;
    sb_t    sbq[$];
    vec_t   tab[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer convolution, magnitude, shift, saturate.
    function automatic logic [OW-1:0] model(input logic [DINW-1:0] d, input logic [KTW-1:0] k,
                                            input logic [DIVW-1:0] dv, input logic md);
        logic [OW-1:0] r;
        logic signed [KW-1:0] kk;
        int s, m, sh;
        r = '0;
        sh = (int'(dv) > SW - 1) ? SW - 1 : int'(dv);
        for (int c = 0; c < NCH; c++) begin
            s = 0;
            for (int t = 0; t < NTAPS; t++) begin
                kk = k[t*KW +: KW];
                s += int'(d[(t*NCH+c)*CW +: CW]) * int'(kk);
            end
            if (s < 0) m = md ? 0 : -s;
            else       m = s;
`ifdef CONV_ALU_ROUND_EN
            if (sh > 0) m += (1 << (sh - 1));
`endif
            m = m >> sh;
            if (m > (1 << CW) - 1) m = (1 << CW) - 1;
            r[c*CW +: CW] = CW'(m);
        end
        return r;
    endfunction

    function automatic logic [DINW-1:0] rep_din(input logic [OW-1:0] w);
        logic [DINW-1:0] r;
        for (int t = 0; t < NTAPS; t++) r[t*OW +: OW] = w;
        return r;
    endfunction

    function automatic logic [KTW-1:0] centre_k(input logic [KW-1:0] k);
        logic [KTW-1:0] r;
        r = '0;
        r[4*KW +: KW] = k;
        return r;
    endfunction

    function automatic logic [KTW-1:0] all_k(input logic [KW-1:0] k);
        logic [KTW-1:0] r;
        for (int t = 0; t < NTAPS; t++) r[t*KW +: KW] = k;
        return r;
    endfunction

    function automatic logic [DINW-1:0] rand_din();
        logic [DINW-1:0] r;
        for (int i = 0; i < NTAPS*NCH; i++) r[i*CW +: CW] = CW'($urandom);
        return r;
    endfunction

    function automatic logic [KTW-1:0] rand_k();
        logic [KTW-1:0] r;
        for (int t = 0; t < NTAPS; t++) r[t*KW +: KW] = KW'($urandom);
        return r;
    endfunction

    // Scoreboard, stall-freeze check and stall observation at the negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            prev_hold = 1'b0;
        end else begin
            sb_t e;
            if (!in_ready) saw_stall = 1'b1;
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_dout", 32'(dout), 32'(prev_dout));
                chk("hold_waddr", 32'(waddr), 32'(prev_waddr));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got waddr %0h dout %0h expected no beat", waddr, dout);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_dout", 32'(dout), 32'(e.dout));
                    chk("sb_waddr", 32'(waddr), 32'(e.waddr));
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_dout  = dout;
            prev_waddr = waddr;
            if (in_valid && in_ready) begin
                e.dout  = model(din, kernel, div, mode);
                e.waddr = raddr;
                sbq.push_back(e);
            end
        end
    end

    // Present a beat and hold it until accepted; returns cycles taken.
    task automatic drive_beat(input logic [DINW-1:0] d, input logic [KTW-1:0] k,
                              input logic [DIVW-1:0] dv, input logic md,
                              input logic [AW-1:0] a, output int cnt);
        logic acc;
        din = d; kernel = k; div = dv; mode = md; raddr = a;
        in_valid = 1'b1;
        acc = 1'b0;
        cnt = 0;
        while (!acc && cnt < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cnt++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no acceptance expected acceptance within 50 cycles");
        end
    endtask

    initial begin
        int cnt, lat, n0;
        logic [OW-1:0] e6, e7, e10;
`ifdef CONV_ALU_ROUND_EN
        e6 = 12'h222; e7 = 12'h111; e10 = 12'h257;
`else
        e6 = 12'h111; e7 = 12'h000; e10 = 12'h246;
`endif
        tab[0]  = '{rep_din(12'hABC), centre_k(5'd1),  4'd0,  1'b0, 12'hABC};
        tab[1]  = '{rep_din(12'hFFF), all_k(5'd1),     4'd0,  1'b0, 12'hFFF};
        tab[2]  = '{rep_din(12'hFFF), all_k(5'd1),     4'd4,  1'b0, 12'h888};
        tab[3]  = '{rep_din(12'h123), centre_k(5'h1F), 4'd0,  1'b0, 12'h123};
        tab[4]  = '{rep_din(12'h123), centre_k(5'h1F), 4'd0,  1'b1, 12'h000};
        tab[5]  = '{rep_din(12'h888), centre_k(5'd3),  4'd4,  1'b0, e6};
        tab[6]  = '{rep_din(12'hFFF), all_k(5'h10),    4'd15, 1'b0, e7};
        tab[7]  = '{rep_din(12'hFFF), all_k(5'h10),    4'd8,  1'b0, 12'h888};
        tab[8]  = '{rep_din(12'h111), all_k(5'd1),     4'd0,  1'b1, 12'h999};
        tab[9]  = '{rep_din(12'h123), all_k(5'd1),     4'd2,  1'b0, e10};
        tab[10] = '{rep_din(12'hFFF), all_k(5'h10),    4'd0,  1'b1, 12'h000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        din = '0; kernel = '0; div = '0; mode = 1'b0; raddr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, one at a time through an idle pipe.
        for (int i = 0; i < 11; i++) begin
            drive_beat(tab[i].din, tab[i].kernel, tab[i].div, tab[i].mode, AW'(12'h100 + i), cnt);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tab[i].exp));
            chk($sformatf("vec%0d_waddr", i), 32'(waddr), 32'(12'h100 + i));
            $display("vec %0d: dout=%03h waddr=%03h latency=%0d", i, dout, waddr, lat);
            @(posedge clk);
            #1;
        end

        // Backpressure: six beats while the sink refuses for five cycles.
        n0 = n_out;
        saw_stall = 1'b0;
        fork
            begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                for (int i = 1; i <= 6; i++) begin
                    int c2;
                    drive_beat(rand_din(), rand_k(), 4'($urandom_range(0, 6)), 1'($urandom), AW'(i), c2);
                end
                in_valid = 1'b0;
            end
        join
        cnt = 0;
        while ((n_out - n0) < 6 && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("bp_count", 32'(n_out - n0), 32'd6);
        chk("bp_in_ready_dropped", 32'(saw_stall), 32'd1);
        $display("backpressure: %0d results delivered", n_out - n0);

        // Reset with three beats in flight (output stalled so none escapes).
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive_beat(rand_din(), all_k(5'd1), 4'd0, 1'b0, AW'(12'h200 + i), cnt);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_waddr", 32'(waddr), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        drive_beat(rep_din(12'h555), centre_k(5'd1), 4'd0, 1'b0, AW'(12'h2AA), cnt);
        in_valid = 1'b0;
        chk("post_rst_accept_cycles", 32'(cnt), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_outs", 32'(n_out - n0), 32'd1);
        $display("mid-stream reset: %0d beats after release", n_out - n0);

        // Randomized stream with random valid/ready.
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = 1'($urandom);
            din       = rand_din();
            kernel    = rand_k();
            div       = DIVW'($urandom);
            mode      = 1'($urandom);
            raddr     = AW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while ((sbq.size() != 0 || out_valid) && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        $display("random stream: %0d results total", n_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_alu_pipe.md
CONV_ALU_PIPE -- requirements
Module: conv_alu_pipe

Interface
REQ-001 SHALL provide these parameters:
- NTAPS, default 9: kernel taps (window elements), ≥2.
- NCH, default 3: colour channels per pixel.
- CW, default 4: bits per channel, unsigned.
- KW, default 5: bits per kernel coefficient, two's complement.
- DIVW, default 4: width of the shift-divide field.
- AW, default 12: frame-buffer address width.

REQ-002 SHALL provide these ports, with clock and reset first:
- clk: input, 1 bit; single clock.
- rst_n: input, 1 bit; reset is synchronous and active-low.
- in_valid: input, 1 bit; input beat valid.
- in_ready: output, 1 bit; block accepts a beat this cycle.
- din: input, NTAPS*NCH*CW bits; tap t, channel c at bit offset (t*NCH+c)*CW.
- kernel: input, NTAPS*KW bits; tap t at bit offset t*KW.
- div: input, DIVW bits; right-shift amount applied to each sum.
- mode: input, 1 bit; 0 = absolute value, 1 = clamp negative results to zero.
- raddr: input, AW bits; address tag carried alongside the beat.
- out_valid: output, 1 bit; result beat valid.
- out_ready: input, 1 bit; downstream accepts the result.
- dout: output, NCH*CW bits; channel c at bit offset c*CW.
- waddr: output, AW bits; raddr of the beat that produced dout.

Function
REQ-003 SHALL implement a 3-stage pipeline:
- S1 registers the NTAPS*NCH signed products (CW+KW bits each; din zero-extended, kernel sign-extended).
- S2 registers per-channel sums of width SW = CW+KW+clog2(NTAPS).
- S3 registers the final dout and waddr.

REQ-004 SHALL carry per-stage valid bits; an accepted beat appears on out_valid exactly 3 cycles later when there is no stall.

REQ-005 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid || out_ready, which is also the global advance enable.

REQ-006 SHALL freeze every stage register, including valids, dout and waddr, while out_valid && !out_ready; no beat is dropped or duplicated.

REQ-007 SHALL insert a bubble (stage valid = 0) when the pipeline advances with in_valid low.

REQ-008 SHALL form the magnitude in S3:
- mode=0: |sum|.
- mode=1: 0 if sum < 0, else sum.

REQ-009 SHALL right-shift the magnitude by div; div values above SW-1 act as SW-1.

REQ-010 SHALL saturate each channel to 2^CW-1 when the shifted magnitude exceeds 2^CW-1.

REQ-011 SHALL compute the most negative sum's magnitude in SW+1 bits so that it saturates rather than wraps.

REQ-012 SHALL sample div and mode together with din at acceptance and carry them down the pipeline, so mid-stream changes affect only later beats.

REQ-013 SHALL carry raddr alongside its beat unchanged and present it on waddr.

Reset
REQ-014 SHALL, on a rising clk edge with rst_n = 0:
- clear all stage valids, so out_valid = 0;
- drive dout = 0 and waddr = 0;
- drive in_ready = 1 from the following cycle.

REQ-015 SHALL discard all in-flight beats when reset is asserted mid-operation; no stale beat emerges after reset release.

REQ-016 SHALL accept a beat on the first cycle after rst_n returns high.

Configuration
REQ-017 SHALL honour macro CONV_ALU_ROUND_EN:
- Defined: before the shift in REQ-009, add 2^(div-1) to the magnitude when div > 0 (round-half-up), with saturation still applied afterwards.
- Undefined: truncate; no rounding adder is present.

Verification
REQ-018 Identity: kernel centre tap (t=4) = 1, others 0, din all taps 0xABC, div=0 -> dout=0xABC three cycles after acceptance.

REQ-019 Saturate and divide: all kernel = 1, all channels 0xF:
- div=0 -> sum 135, dout=0xFFF.
- div=4 -> dout=0x888.

REQ-020 Sign and mode: centre tap = -1, din 0x123:
- mode=0 -> 0x123.
- mode=1 -> 0x000.

REQ-021 Backpressure: stream 6 beats with raddr 1..6 while out_ready is held low for 5 cycles -> in_ready drops; all 6 results emerge in order with matching waddr; none lost.

REQ-022 Reset mid-stream: assert rst_n=0 for 1 cycle with 3 beats in flight -> out_valid=0, dout=0; no result from those beats appears afterwards.

REQ-023 Rounding: centre tap = 3, din 0x888, div=4:
- CONV_ALU_ROUND_EN undefined -> dout=0x111.
- CONV_ALU_ROUND_EN defined -> dout=0x222.
